// File: rtl/frog_position.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : frog_position                                                  |
// | Purpose : Frog position tracker on a ROWS x COLS grid. It handles hop    |
// |           lockout, death freeze and respawn, and drives a one-hot light. |
// | Config  : define FROG_WRAP_EN so that horizontal moves wrap at the edges.|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module frog_position #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int START_COL    = 3,
  parameter int HOP_CYCLES   = 2,
  parameter int DEATH_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    L,
  input  logic                    R,
  input  logic                    U,
  input  logic                    D,
  input  logic                    crash,
  input  logic                    win,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic [ROWS*COLS-1:0]    lights,
  output logic                    alive,
  output logic [7:0]              hop_count
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int IW   = $clog2(ROWS*COLS);
  localparam int TMAX = (HOP_CYCLES > DEATH_CYCLES) ? HOP_CYCLES : DEATH_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
  localparam logic [CW-1:0] SPAWN_COL  = CW'(START_COL);
  localparam logic [TW-1:0] HOP_LOAD   = TW'(HOP_CYCLES - 1);
  localparam logic [TW-1:0] DEATH_LOAD = TW'(DEATH_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOP  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  logic [1:0]    state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [RW-1:0] row_nx, row_mv;
  logic [CW-1:0] col_nx, col_mv;
  logic [7:0]    hop_nx;
  logic          move_ok;
  logic [IW-1:0] light_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      row       <= '0;
      col       <= SPAWN_COL;
      hop_count <= 8'd0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      row       <= row_nx;
      col       <= col_nx;
      hop_count <= hop_nx;
    end
  end

  // A move is accepted only when exactly one direction is requested and the target stays on the grid.
  always_comb begin
    move_ok = 1'b0;
    row_mv  = row;
    col_mv  = col;
    if ($onehot({L, R, U, D})) begin
      if (U && (row != ROW_MAX)) begin
        row_mv  = row + 1'b1;
        move_ok = 1'b1;
      end
      if (D && (row != '0)) begin
        row_mv  = row - 1'b1;
        move_ok = 1'b1;
      end
`ifdef FROG_WRAP_EN
      if (R) begin
        col_mv  = (col == COL_MAX) ? '0 : col + 1'b1;
        move_ok = 1'b1;
      end
      if (L) begin
        col_mv  = (col == '0) ? COL_MAX : col - 1'b1;
        move_ok = 1'b1;
      end
`else
      if (R && (col != COL_MAX)) begin
        col_mv  = col + 1'b1;
        move_ok = 1'b1;
      end
      if (L && (col != '0)) begin
        col_mv  = col - 1'b1;
        move_ok = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    row_nx   = row;
    col_nx   = col;
    hop_nx   = hop_count;
    case (state)
      S_IDLE, S_HOP: begin
        if (crash) begin
          state_nx = S_DEAD;
          timer_nx = DEATH_LOAD;
        end else if (win) begin
          state_nx = S_IDLE;
          timer_nx = '0;
          row_nx   = '0;
          col_nx   = SPAWN_COL;
          hop_nx   = 8'd0;
        end else if (state == S_IDLE) begin
          if (move_ok) begin
            state_nx = S_HOP;
            timer_nx = HOP_LOAD;
            row_nx   = row_mv;
            col_nx   = col_mv;
            hop_nx   = (hop_count == 8'hFF) ? hop_count : hop_count + 8'd1;
          end
        end else if (timer == '0) begin
          state_nx = S_IDLE;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      S_DEAD: begin
        if (timer == '0) begin
          state_nx = S_IDLE;
          row_nx   = '0;
          col_nx   = SPAWN_COL;
          hop_nx   = 8'd0;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    alive     = (state != S_DEAD);
    light_idx = IW'(row * COLS + col);
    lights    = '0;
    if (alive) lights[light_idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_frog_position.sv
`default_nettype none
// Self-checking bench for frog_position: directed vector table, corner sequences
// and randomized traffic compared against a cycle-counting reference model.
module tb_frog_position;

  localparam int ROWS = 8, COLS = 8, START_COL = 3, HOP_CYCLES = 2, DEATH_CYCLES = 4;
  localparam int N = ROWS * COLS;

  // Input encoding {L,R,U,D,crash,win}
  localparam logic [5:0] I_N = 6'b000000, I_L = 6'b100000, I_R = 6'b010000;
  localparam logic [5:0] I_U = 6'b001000, I_D = 6'b000100, I_C = 6'b000010, I_W = 6'b000001;

  logic clock = 1'b0, reset = 1'b0;
  logic L = 1'b0, R = 1'b0, U = 1'b0, D = 1'b0, crash = 1'b0, win = 1'b0;
  logic [2:0] row, col;
  logic [N-1:0] lights;
  logic alive;
  logic [7:0] hop_count;

  int checks = 0, failures = 0;
  int m_row, m_col, m_hops, m_busy, m_dead;

  typedef struct {
    logic [5:0] in;
    int r;
    int c;
    int h;
    bit a;
  } vec_t;
  vec_t tbl[19];

  frog_position #(.ROWS(ROWS), .COLS(COLS), .START_COL(START_COL),
                  .HOP_CYCLES(HOP_CYCLES), .DEATH_CYCLES(DEATH_CYCLES)) dut (
    .clock(clock), .reset(reset), .L(L), .R(R), .U(U), .D(D),
    .crash(crash), .win(win), .row(row), .col(col), .lights(lights),
    .alive(alive), .hop_count(hop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] light_of(input int r, input int c, input bit a);
    logic [N-1:0] v;
    v = '0;
    if (a) v[r*COLS+c] = 1'b1;
    return v;
  endfunction

  task automatic check_pos(input string name, input int r, input int c, input int h, input bit a);
    check({name, ".row"},    64'(row),       64'(r));
    check({name, ".col"},    64'(col),       64'(c));
    check({name, ".hops"},   64'(hop_count), 64'(h));
    check({name, ".alive"},  64'(alive),     64'(a));
    check({name, ".lights"}, lights,         light_of(r, c, a));
  endtask

  task automatic cyc(input logic [5:0] v);
    {L, R, U, D, crash, win} = v;
    @(posedge clock);
    #1;
    {L, R, U, D, crash, win} = I_N;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic model_spawn();
    m_row = 0; m_col = START_COL; m_hops = 0; m_busy = 0; m_dead = 0;
  endtask

  // Frog rules in plain integers: a move locks out HOP_CYCLES further cycles,
  // a crash freezes DEATH_CYCLES cycles and the last frozen cycle ends in respawn.
  task automatic model_edge(input logic [5:0] v, input bit rs);
    int nmoves, nr, nc;
    nmoves = int'(v[5]) + int'(v[4]) + int'(v[3]) + int'(v[2]);
    if (rs) begin
      model_spawn();
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) model_spawn();
    end else if (v[1]) begin
      m_dead = DEATH_CYCLES;
      m_busy = 0;
    end else if (v[0]) begin
      model_spawn();
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (nmoves == 1) begin
      nr = m_row + int'(v[3]) - int'(v[2]);
      nc = m_col + int'(v[4]) - int'(v[5]);
`ifdef FROG_WRAP_EN
      if (nc < 0) nc = COLS - 1;
      if (nc >= COLS) nc = 0;
`endif
      if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
        m_row = nr;
        m_col = nc;
        m_hops = (m_hops < 255) ? m_hops + 1 : 255;
        m_busy = HOP_CYCLES;
      end
    end
  endtask

  initial begin
    logic [5:0] v;
    bit rs;

    tbl[0]  = '{I_U, 1, 3, 1, 1'b1};
    tbl[1]  = '{I_U, 1, 3, 1, 1'b1};
    tbl[2]  = '{I_N, 1, 3, 1, 1'b1};
    tbl[3]  = '{I_L | I_U, 1, 3, 1, 1'b1};
    tbl[4]  = '{I_R | I_D, 1, 3, 1, 1'b1};
    tbl[5]  = '{I_D, 0, 3, 2, 1'b1};
    tbl[6]  = '{I_N, 0, 3, 2, 1'b1};
    tbl[7]  = '{I_N, 0, 3, 2, 1'b1};
    tbl[8]  = '{I_D, 0, 3, 2, 1'b1};
    tbl[9]  = '{I_L, 0, 2, 3, 1'b1};
    tbl[10] = '{I_N, 0, 2, 3, 1'b1};
    tbl[11] = '{I_N, 0, 2, 3, 1'b1};
    tbl[12] = '{I_L, 0, 1, 4, 1'b1};
    tbl[13] = '{I_N, 0, 1, 4, 1'b1};
    tbl[14] = '{I_N, 0, 1, 4, 1'b1};
    tbl[15] = '{I_L, 0, 0, 5, 1'b1};
    tbl[16] = '{I_N, 0, 0, 5, 1'b1};
    tbl[17] = '{I_N, 0, 0, 5, 1'b1};
`ifdef FROG_WRAP_EN
    tbl[18] = '{I_L, 0, 7, 6, 1'b1};
`else
    tbl[18] = '{I_L, 0, 0, 5, 1'b1};
`endif

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1 check_pos("reset_async", 0, START_COL, 0, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    check_pos("reset", 0, START_COL, 0, 1'b1);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].in);
      check_pos($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].h, tbl[i].a);
    end

    // crash and win together at row 4: four frozen cycles, then respawn
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(I_U); cyc(I_N); cyc(I_N);
    end
    check_pos("climb4", 4, 3, 4, 1'b1);
    cyc(I_C | I_W);
    check_pos("dead0", 4, 3, 4, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc(I_U | I_C | I_W);
      check_pos($sformatf("dead%0d", i), 4, 3, 4, 1'b0);
    end
    cyc(I_N);
    check_pos("respawn", 0, START_COL, 0, 1'b1);

    // win during HOP at row 7, then an immediate move
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(I_U); cyc(I_N); cyc(I_N);
    end
    cyc(I_U);
    check_pos("row7", 7, 3, 7, 1'b1);
    cyc(I_W);
    check_pos("win_hop", 0, START_COL, 0, 1'b1);
    cyc(I_U);
    check_pos("after_win", 1, 3, 1, 1'b1);
    cyc(I_N); cyc(I_N);

    // asynchronous reset in the middle of DEAD
    cyc(I_C);
    cyc(I_N); cyc(I_N);
    #2 reset = 1'b1;
    #1 check_pos("async_dead", 0, START_COL, 0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    cyc(I_U);
    check_pos("post_dead_rst", 1, 3, 1, 1'b1);

    // asynchronous reset in the middle of HOP leaves no lockout
    cyc(I_R);
    #2 reset = 1'b1;
    #1 check_pos("async_hop", 0, START_COL, 0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    cyc(I_U);
    check_pos("post_hop_rst", 1, 3, 1, 1'b1);

    // hop_count saturates at 255
    do_reset();
    for (int i = 0; i < 260; i++) begin
      cyc((i % 2 == 0) ? I_U : I_D); cyc(I_N); cyc(I_N);
    end
    check("saturate", 64'(hop_count), 64'd255);

    // randomized traffic against the reference model
    do_reset();
    model_spawn();
    for (int n = 0; n < 3000; n++) begin
      v[5] = ($urandom_range(0, 99) < 30);
      v[4] = ($urandom_range(0, 99) < 30);
      v[3] = ($urandom_range(0, 99) < 30);
      v[2] = ($urandom_range(0, 99) < 30);
      v[1] = ($urandom_range(0, 99) < 3);
      v[0] = ($urandom_range(0, 99) < 4);
      rs   = ($urandom_range(0, 199) < 1);
      model_edge(v, rs);
      reset = rs;
      cyc(v);
      reset = 1'b0;
      check_pos($sformatf("rand%0d", n), m_row, m_col, m_hops, m_dead == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frog_position.md
FROG_POSITION -- requirements
Module: frog_position

Interface
REQ-001 Parameter ROWS, default 8: grid rows (2..32); row 0 is the start lane, row ROWS-1 is the goal lane.
REQ-002 Parameter COLS, default 8: grid columns (2..32).
REQ-003 Parameter START_COL, default 3: spawn column (0..COLS-1); spawn row is always 0.
REQ-004 Parameter HOP_CYCLES, default 2: lockout cycles after an accepted move (>=1).
REQ-005 Parameter DEATH_CYCLES, default 4: frozen cycles after a crash before respawn (>=1).
REQ-006 clock  in  1  sole clock; all state changes on posedge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 L, R, U, D  in  1 each  move requests, single-cycle pulses from upstream edge detectors.
REQ-009 crash  in  1  collision with an obstacle, sampled on the clock.
REQ-010 win  in  1  goal reached, sampled on the clock.
REQ-011 row  out  $clog2(ROWS)  current frog row.
REQ-012 col  out  $clog2(COLS)  current frog column.
REQ-013 lights  out  ROWS*COLS  one-hot frog light; bit index row*COLS+col.
REQ-014 alive  out  1  high in IDLE and HOP, low in DEAD.
REQ-015 hop_count  out  8  accepted moves since the last spawn, saturating at 255.

Function
REQ-016 The block SHALL implement three states: IDLE, HOP and DEAD; all outputs are registered or decoded only from registered state.
REQ-017 A move is valid only when exactly one of L/R/U/D is high; any other combination SHALL be ignored.
REQ-018 In IDLE, a valid move SHALL update row/col on that clock edge (visible the next cycle), increment hop_count, load the timer with HOP_CYCLES-1 and enter HOP.
REQ-019 U SHALL increment row, D decrement row, R increment col, L decrement col.
REQ-020 A move past a grid edge SHALL leave the position unchanged, SHALL NOT count as a hop, and SHALL stay in IDLE.
REQ-021 In HOP, all move inputs SHALL be ignored; the timer decrements each cycle and the block returns to IDLE on the edge where the timer equals 0.
REQ-022 crash in IDLE or HOP SHALL enter DEAD, hold row/col, load the timer with DEATH_CYCLES-1 and drive lights to all zeros.
REQ-023 In DEAD, moves, crash and win SHALL be ignored; when the timer reaches 0, row=0, col=START_COL, hop_count=0 and the next state is IDLE.
REQ-024 win in IDLE or HOP SHALL set row=0, col=START_COL, hop_count=0 and enter IDLE on the same edge.
REQ-025 Simultaneous events SHALL be prioritised crash > win > move; any lower-priority event in the same cycle is dropped.
REQ-026 lights SHALL have exactly one bit set whenever alive=1.

Reset
REQ-027 While reset is asserted, the block SHALL asynchronously force state=IDLE, row=0, col=START_COL, hop_count=0 and timer=0, giving alive=1 and lights bit START_COL set.
REQ-028 Reset asserted in the middle of HOP or DEAD SHALL abort that state immediately; there is no residual lockout after release.

Configuration
REQ-029 Macro FROG_WRAP_EN: when defined, an L move at col 0 SHALL go to COLS-1 and an R move at COLS-1 SHALL go to col 0, each counting as an accepted hop; vertical edges still block per REQ-020.
REQ-030 When FROG_WRAP_EN is undefined, all four edges SHALL behave per REQ-020.

Verification
REQ-031 Reset, then a U pulse -> next cycle row=1, col=3, lights[11]=1, hop_count=1; a second U pulse in the next cycle is ignored (HOP).
REQ-032 L and U high together in IDLE -> no change to position or hop_count; state remains IDLE.
REQ-033 At col=0, an L pulse -> col stays 0 and hop_count is unchanged (no wrap); with FROG_WRAP_EN defined -> col=7 and hop_count is incremented.
REQ-034 crash and win high in the same cycle at row=4 -> alive=0 and lights=0 for 4 cycles, then row=0, col=3, alive=1, hop_count=0.
REQ-035 win during HOP at row=7 -> next cycle row=0, col=3, IDLE, and a U pulse is accepted immediately.
REQ-036 Reset asserted asynchronously mid-DEAD -> outputs return to spawn values before the next clock edge, with alive=1.
